// File: rtl/mux_reg_n_1.sv
// Registered N:1 multiplexer with per-channel valid/ready and a two-entry output skid buffer.
// in_ready is built from the selector and a flop only, so out_ready never reaches it combinationally.
module mux_reg_n_1 #(
    parameter int WIDTH  = 32,
    parameter int INPUTS = 4,
    parameter int SEL_W  = $clog2(INPUTS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [INPUTS*WIDTH-1:0] in_data,
    input  logic [INPUTS-1:0]       in_valid,
    output logic [INPUTS-1:0]       in_ready,
    input  logic [SEL_W-1:0]        selector,
    output logic [WIDTH-1:0]        out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   out_reg;
    logic [WIDTH-1:0]   skid_reg;
    logic               out_valid_reg;
    logic               skid_valid_reg;

    logic               sel_ok;
    logic [WIDTH-1:0]   chan [INPUTS];
    logic [INPUTS-1:0]  hit;
    logic [WIDTH-1:0]   sel_data;
    logic               accept;

    // Selector values at or above INPUTS select nothing, leaving data held upstream.
    assign sel_ok = ({{(32-SEL_W){1'b0}}, selector} < 32'(INPUTS));

    for (genvar gi = 0; gi < INPUTS; gi++) begin : g_chan
        assign chan[gi]     = in_data[gi*WIDTH +: WIDTH];
        assign hit[gi]      = sel_ok && (selector == SEL_W'(gi));
        assign in_ready[gi] = hit[gi] && !skid_valid_reg && !reset;
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < INPUTS; k++) begin
            if (hit[k]) begin
                sel_data = chan[k];
            end
        end
    end

    assign accept = |(in_valid & in_ready);

    // out_reg is the head word, skid_reg the second; words always leave from out_reg.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= EMPTY;
            out_reg        <= '0;
            skid_reg       <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        out_reg       <= sel_data;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && out_ready) begin
                        out_reg <= sel_data;
                    end else if (accept) begin
                        skid_reg       <= sel_data;
                        skid_valid_reg <= 1'b1;
                        state_reg      <= TWO;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        out_reg        <= skid_reg;
                        skid_valid_reg <= 1'b0;
                        state_reg      <= ONE;
                    end
                end
                default: begin
                    state_reg      <= EMPTY;
                    out_valid_reg  <= 1'b0;
                    skid_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_reg_n_1.sv
// Bench for mux_reg_n_1: a two-deep FIFO model checked every cycle, directed scenarios, random traffic.
module tb_mux_reg_n_1;

    localparam int WIDTH  = 32;
    localparam int INPUTS = 4;
    localparam int SEL_W  = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                    reset = 1'b1;
    logic [INPUTS*WIDTH-1:0] in_data = '0;
    logic [INPUTS-1:0]       in_valid = '0;
    logic [INPUTS-1:0]       in_ready;
    logic [SEL_W-1:0]        selector = '0;
    logic [WIDTH-1:0]        out;
    logic                    out_valid;
    logic                    out_ready = 1'b0;

    mux_reg_n_1 #(.WIDTH(WIDTH), .INPUTS(INPUTS)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .selector(selector), .out(out), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // Three-channel instance for the out-of-range selector case.
    logic [3*WIDTH-1:0] in_data3 = '0;
    logic [2:0]         in_valid3 = 3'b111;
    logic [2:0]         in_ready3;
    logic [1:0]         selector3 = 2'd3;
    logic [WIDTH-1:0]   out3;
    logic               out_valid3;
    logic               out_ready3 = 1'b0;

    mux_reg_n_1 #(.WIDTH(WIDTH), .INPUTS(3)) dut3 (
        .clock(clock), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .selector(selector3), .out(out3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0]  mq[$];
    logic [WIDTH-1:0]  m_last = '0;
    logic [INPUTS-1:0] s_rdy;
    logic [WIDTH-1:0]  s_out;
    logic              s_ov;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [INPUTS*WIDTH-1:0] pack(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                                                     input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // One clock cycle: drive, compare DUT against the FIFO model, then advance the model at the edge.
    task automatic cycle(input logic rst, input logic [SEL_W-1:0] sel, input logic [INPUTS-1:0] v,
                         input logic [INPUTS*WIDTH-1:0] d, input logic ordy);
        logic [INPUTS-1:0] exp_rdy;
        logic [WIDTH-1:0]  exp_out;
        logic              acc;
        logic [WIDTH-1:0]  word;
        @(negedge clock);
        reset = rst; selector = sel; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        exp_rdy = '0;
        if (!rst && mq.size() < 2 && int'(sel) < INPUTS) exp_rdy[sel] = 1'b1;
        exp_out = (mq.size() > 0) ? mq[0] : m_last;
        s_rdy = in_ready; s_out = out; s_ov = out_valid;
        check("in_ready", 128'(in_ready), 128'(exp_rdy));
        check("out_valid", 128'(out_valid), 128'(mq.size() > 0));
        check("out", 128'(out), 128'(exp_out));
        acc  = |(v & exp_rdy);
        word = d[int'(sel)*WIDTH +: WIDTH];
        @(posedge clock);
        if (rst) begin
            mq.delete();
            m_last = '0;
        end else begin
            m_last = exp_out;
            if (mq.size() > 0 && ordy) void'(mq.pop_front());
            if (acc) mq.push_back(word);
        end
        $display("cyc rst=%0b sel=%0d v=%b ordy=%0b rdy=%b out=%0h ov=%0b q=%0d",
                 rst, sel, v, ordy, s_rdy, s_out, s_ov, mq.size());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 4'b0000, '0, 1'b1);
    endtask

    initial begin
        logic [INPUTS*WIDTH-1:0] rd;
        logic [INPUTS*WIDTH-1:0] ld;

        // Reset with every channel valid and selector 2.
        cycle(1'b1, 2'd2, 4'b1111, pack(1, 2, 3, 4), 1'b0);
        check("rst_ready", 128'(s_rdy), 128'(4'b0000));
        check("rst_out", 128'(s_out), 128'(0));
        check("rst_ov", 128'(s_ov), 128'(0));
        cycle(1'b1, 2'd2, 4'b1111, pack(1, 2, 3, 4), 1'b0);
        cycle(1'b0, 2'd2, 4'b0000, pack(1, 2, 3, 4), 1'b0);
        check("post_rst_ready", 128'(s_rdy), 128'(4'b0100));

        // Out-of-range selector on the three-channel instance.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            check("oor_ready", 128'(in_ready3), 128'(3'b000));
            check("oor_ov", 128'(out_valid3), 128'(0));
        end
        selector3 = 2'd1;
        #1;
        check("inr_ready3", 128'(in_ready3), 128'(3'b010));

        // Streaming with no bubbles.
        cycle(1'b0, 2'd1, 4'b0010, pack(0, 32'hA0, 0, 0), 1'b1);
        cycle(1'b0, 2'd1, 4'b0010, pack(0, 32'hA1, 0, 0), 1'b1);
        check("st_a0", 128'(s_out), 128'(32'hA0));
        cycle(1'b0, 2'd1, 4'b0010, pack(0, 32'hA2, 0, 0), 1'b1);
        check("st_a1", 128'(s_out), 128'(32'hA1));
        check("st_ov", 128'(s_ov), 128'(1));
        cycle(1'b0, 2'd1, 4'b0000, '0, 1'b1);
        check("st_a2", 128'(s_out), 128'(32'hA2));
        idle(2);

        // Stall and skid on channel 3.
        cycle(1'b0, 2'd3, 4'b1000, pack(0, 0, 0, 32'h11), 1'b0);
        cycle(1'b0, 2'd3, 4'b1000, pack(0, 0, 0, 32'h22), 1'b0);
        check("sk_rdy1", 128'(s_rdy), 128'(4'b1000));
        cycle(1'b0, 2'd3, 4'b1000, pack(0, 0, 0, 32'h33), 1'b0);
        check("sk_rdy_full", 128'(s_rdy), 128'(4'b0000));
        check("sk_hold", 128'(s_out), 128'(32'h11));
        cycle(1'b0, 2'd3, 4'b1000, pack(0, 0, 0, 32'h33), 1'b1);
        check("sk_out11", 128'(s_out), 128'(32'h11));
        cycle(1'b0, 2'd3, 4'b1000, pack(0, 0, 0, 32'h33), 1'b1);
        check("sk_out22", 128'(s_out), 128'(32'h22));
        cycle(1'b0, 2'd3, 4'b0000, '0, 1'b1);
        check("sk_out33", 128'(s_out), 128'(32'h33));
        cycle(1'b0, 2'd3, 4'b0000, '0, 1'b1);
        check("sk_empty", 128'(s_ov), 128'(0));
        check("sk_retain", 128'(s_out), 128'(32'h33));

        // Selector switch mid-stream.
        cycle(1'b0, 2'd0, 4'b0001, pack(32'h55, 0, 32'h77, 0), 1'b1);
        cycle(1'b0, 2'd2, 4'b0101, pack(32'h55, 0, 32'h77, 0), 1'b1);
        check("sw_55", 128'(s_out), 128'(32'h55));
        check("sw_rdy", 128'(s_rdy), 128'(4'b0100));
        cycle(1'b0, 2'd2, 4'b0001, pack(32'h55, 0, 32'h77, 0), 1'b1);
        check("sw_77", 128'(s_out), 128'(32'h77));
        check("sw_rdy0", 128'(s_rdy[0]), 128'(0));
        idle(2);

        // Reset while two words are buffered.
        cycle(1'b0, 2'd1, 4'b0010, pack(0, 32'h01, 0, 0), 1'b0);
        cycle(1'b0, 2'd1, 4'b0010, pack(0, 32'h02, 0, 0), 1'b0);
        cycle(1'b0, 2'd1, 4'b0000, '0, 1'b0);
        check("two_out", 128'(s_out), 128'(32'h01));
        cycle(1'b1, 2'd1, 4'b0010, pack(0, 32'h09, 0, 0), 1'b1);
        cycle(1'b0, 2'd1, 4'b0010, pack(0, 32'h03, 0, 0), 1'b0);
        check("rt_out", 128'(s_out), 128'(0));
        check("rt_ov", 128'(s_ov), 128'(0));
        cycle(1'b0, 2'd1, 4'b0000, '0, 1'b1);
        check("rt_first", 128'(s_out), 128'(32'h03));
        idle(2);

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < INPUTS; k++) rd[k*WIDTH +: WIDTH] = $urandom;
            ld = rd;
            cycle(($urandom_range(0, 63) == 0), SEL_W'($urandom_range(0, 3)),
                  INPUTS'($urandom), ld, ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
